m_stack_ctrl: RTL

//  Push/pop sequencer for the CPU hardware stack; the stage directly upstream of the

---
 rtl/m_stack_pkg.sv | 21 ++
 rtl/m_stack_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/m_stack_pkg.sv
// Types and address-map constants shared by the stack sequencer and the memory address checker.
package m_stack_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} stk_state_t;

  localparam logic [11:0] STACK_TOP = 12'hFFF;
  localparam logic [11:0] STACK_LIM = 12'h44C;
  localparam logic [11:0] MMR_LO    = 12'h401;
  localparam logic [11:0] MMR_HI    = 12'h44B;

  // Region decode used by the address checker: 0 = instruction, 1 = MMR, 2 = stack.
  function automatic logic [1:0] addr_sel(input logic [11:0] a);
    if (a < MMR_LO) begin
      return 2'd0;
    end else if (a <= MMR_HI) begin
      return 2'd1;
    end
    return 2'd2;
  endfunction

endpackage

// File: rtl/m_stack_ctrl.sv
// Hardware stack sequencer: owns SP, runs the push/pop handshake, drives stack RAM
// and keeps every write strobe inside the stack window.
//
// state | meaning
// IDLE  | ready=1; accept push (priority) or pop, or flag overflow/underflow
// WRITE | present addr=SP, wdata, MEMLOAD for one cycle, then SP-1
// READ  | present addr=SP (already incremented) to the stack RAM
// WAIT  | count down RD_LAT cycles, capture mem_rdata on the last one
module m_stack_ctrl #(
  parameter int unsigned       ADDR_W    = 12,
  parameter int unsigned       DATA_W    = 16,
  parameter logic [ADDR_W-1:0] STACK_TOP = m_stack_pkg::STACK_TOP,
  parameter logic [ADDR_W-1:0] STACK_LIM = m_stack_pkg::STACK_LIM,
  parameter int unsigned       RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              MEMLOAD,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [ADDR_W-1:0] sp,
  output logic              empty,
  output logic              full,
  output logic              err_ovf,
  output logic              err_udf,
  input  logic              err_clr
);
  import m_stack_pkg::*;

  localparam logic [ADDR_W-1:0] FULL_SP  = ADDR_W'(STACK_LIM - 1'b1);
  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);

  stk_state_t        state_q, state_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              memload_q, memload_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] push_word_q, push_word_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ready_q, ready_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_udf_q, err_udf_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    addr_d      = addr_q;
    memload_d   = 1'b0;
    wdata_d     = wdata_q;
    push_word_d = push_word_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    cnt_d       = cnt_q;
    // a flag raised in the same cycle as err_clr survives the clear
    err_ovf_d   = err_ovf_q & ~err_clr;
    err_udf_d   = err_udf_q & ~err_clr;

    case (state_q)
      IDLE: begin
        if (push) begin
          if (full_q) begin
            err_ovf_d = 1'b1;
          end else begin
            push_word_d = push_data;
            state_d     = WRITE;
          end
        end else if (pop) begin
          if (empty_q) begin
            pop_data_d  = '0;
            pop_valid_d = 1'b1;
            err_udf_d   = 1'b1;
          end else begin
            sp_d    = sp_q + 1'b1;
            state_d = READ;
          end
        end
      end
      WRITE: begin
        addr_d    = sp_q;
        wdata_d   = push_word_q;
        memload_d = 1'b1;
        sp_d      = sp_q - 1'b1;
        state_d   = IDLE;
      end
      READ: begin
        addr_d  = sp_q;
        cnt_d   = LAT_LAST;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          pop_data_d  = mem_rdata;
          pop_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // status flags follow the next SP so they line up with the registered sp output
    ready_d = (state_d == IDLE);
    empty_d = (sp_d == STACK_TOP);
    full_d  = (sp_d == FULL_SP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sp_q        <= STACK_TOP;
      addr_q      <= STACK_TOP;
      memload_q   <= 1'b0;
      wdata_q     <= '0;
      push_word_q <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ready_q     <= 1'b1;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_udf_q   <= 1'b0;
      cnt_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      addr_q      <= addr_d;
      memload_q   <= memload_d;
      wdata_q     <= wdata_d;
      push_word_q <= push_word_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ready_q     <= ready_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      err_ovf_q   <= err_ovf_d;
      err_udf_q   <= err_udf_d;
      cnt_q       <= cnt_d;
    end
  end

  assign ready     = ready_q;
  assign addr      = addr_q;
  assign MEMLOAD   = memload_q;
  assign wdata     = wdata_q;
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign sp        = sp_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign err_ovf   = err_ovf_q;
  assign err_udf   = err_udf_q;

  // SP must never wrap in either direction; the full/empty guards are what prevent it
  a_no_dec_wrap: assert property (@(posedge clk) disable iff (rst)
    (state_q == WRITE) |-> (sp_q != FULL_SP));
  a_no_inc_wrap: assert property (@(posedge clk) disable iff (rst)
    (state_q == IDLE && pop && !push && !empty_q) |-> (sp_q != STACK_TOP));
  a_wr_window: assert property (@(posedge clk) disable iff (rst)
    memload_q |-> (addr_q >= STACK_LIM && addr_q > MMR_HI));

endmodule
